lcd_cmd_scheduler: RTL and testbench

- Sits between the SPI-fed display logic and the low-level LCD byte engine (`lcdFSM`: data_ready / d / rs in, busy_flag out).
- Owns the engine: runs the HD44780 power-on init sequence, then shares the engine between a command requester and a character requester.
- Enforces the post-command settling delay on every byte, so upstream logic never tracks LCD timing.

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_delay_timer.sv | 29 ++
 rtl/lcd_cmd_scheduler.sv | 142 ++++++++++++++
 tb/tb_lcd_cmd_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared state encoding, HD44780 command bytes and init ROM for the LCD command scheduler.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWRUP,
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      POST_DELAY
   } sched_state_e;

   localparam logic [7:0] CLEAR    = 8'h01;
   localparam logic [7:0] HOME     = 8'h02;
   localparam logic [7:0] HOME_ALT = 8'h03;
   localparam logic [7:0] FUNC_SET = 8'h38;
   localparam logic [7:0] DISP_ON  = 8'h0C;
   localparam logic [7:0] ENTRY    = 8'h06;

   localparam int unsigned INIT_LEN = 6;

   // Entry 0 is the rightmost element: sent first.
   localparam logic [INIT_LEN-1:0][7:0] INIT_ROM =
      {ENTRY, CLEAR, DISP_ON, FUNC_SET, FUNC_SET, FUNC_SET};

   // Clear/home variants need the long settling time; everything else is short.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
      return !rs && (d == CLEAR || d == HOME || d == HOME_ALT);
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter: holds at zero, flags the final counted cycle.
module lcd_delay_timer #(
   parameter int unsigned CNT_W = 18
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             last,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign last = (cnt == CNT_W'(1));
   assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// Owns the LCD byte engine: power-on init, then cmd-over-char arbitration with
// a settling delay enforced after every byte.
module lcd_cmd_scheduler
   import lcd_pkg::*;
#(
   parameter int unsigned POWERUP_CYC = 240000,
   parameter int unsigned LONG_CYC    = 19200,
   parameter int unsigned SHORT_CYC   = 600,
   parameter int unsigned CNT_W       = 18
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   input  logic       char_valid,
   input  logic [7:0] char_data,
   output logic       char_ready,
   output logic       lcd_req,
   output logic [7:0] lcd_d,
   output logic       lcd_rs,
   input  logic       lcd_busy,
   output logic       init_done,
   output logic       sched_busy
);

   localparam bit CNT_FITS =
      (64'(POWERUP_CYC) < (64'd1 << CNT_W)) &&
      (64'(LONG_CYC)    < (64'd1 << CNT_W)) &&
      (64'(SHORT_CYC)   < (64'd1 << CNT_W)) &&
      (POWERUP_CYC >= 2) && (LONG_CYC >= 1) && (SHORT_CYC >= 1);

   sched_state_e     state;
   logic [2:0]       init_idx;
   logic             tmr_load;
   logic             tmr_en;
   logic             tmr_last;
   logic             tmr_zero;
   logic [CNT_W-1:0] tmr_val;

   // Power-up counter starts from zero after reset, so its first cycle loads
   // POWERUP_CYC-1 and the wait still totals exactly POWERUP_CYC cycles.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_en   = (state == PWRUP) || (state == POST_DELAY);
      if (state == PWRUP && tmr_zero) begin
         tmr_load = 1'b1;
         tmr_val  = CNT_W'(POWERUP_CYC - 1);
      end else if (state == WAIT_DONE && !lcd_busy) begin
         tmr_load = 1'b1;
         tmr_val  = is_long_cmd(lcd_rs, lcd_d) ? CNT_W'(LONG_CYC) : CNT_W'(SHORT_CYC);
      end
   end

   lcd_delay_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .last     (tmr_last),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= PWRUP;
         init_idx  <= '0;
         init_done <= 1'b0;
         lcd_req   <= 1'b0;
         lcd_d     <= '0;
         lcd_rs    <= 1'b0;
      end else begin
         lcd_req <= 1'b0;
         unique case (state)
            PWRUP: begin
               if (tmr_last) begin
                  state   <= ISSUE;
                  lcd_req <= 1'b1;
                  lcd_d   <= INIT_ROM[0];
                  lcd_rs  <= 1'b0;
               end
            end
            IDLE: begin
               if (cmd_valid) begin
                  state   <= ISSUE;
                  lcd_req <= 1'b1;
                  lcd_d   <= cmd_data;
                  lcd_rs  <= 1'b0;
               end else if (char_valid) begin
                  state   <= ISSUE;
                  lcd_req <= 1'b1;
                  lcd_d   <= char_data;
                  lcd_rs  <= 1'b1;
               end
            end
            ISSUE: begin
               state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (lcd_busy) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!lcd_busy) begin
                  state <= POST_DELAY;
               end
            end
            POST_DELAY: begin
               if (tmr_last) begin
                  if (init_done) begin
                     state <= IDLE;
                  end else if (init_idx == 3'(INIT_LEN - 1)) begin
                     init_done <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     init_idx <= init_idx + 3'd1;
                     state    <= ISSUE;
                     lcd_req  <= 1'b1;
                     lcd_d    <= INIT_ROM[init_idx + 3'd1];
                     lcd_rs   <= 1'b0;
                  end
               end
            end
            default: begin
               state <= PWRUP;
            end
         endcase
      end
   end

   assign cmd_ready  = (state == IDLE);
   assign char_ready = (state == IDLE) && !cmd_valid;
   assign sched_busy = (state != IDLE);

   cnt_w_fits: assert property (@(posedge clk) CNT_FITS);

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Self-checking bench: timeline model of the scheduler driven by a busy-pulse engine model.
module tb_lcd_cmd_scheduler;

   localparam int unsigned P  = 10;
   localparam int unsigned LG = 8;
   localparam int unsigned SH = 3;
   localparam longint NEVER = 64'sh3fff_ffff_ffff_ffff;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       char_valid = 1'b0;
   logic       lcd_busy = 1'b0;
   logic [7:0] cmd_data = '0;
   logic [7:0] char_data = '0;
   logic       cmd_ready, char_ready, lcd_req, lcd_rs, init_done, sched_busy;
   logic [7:0] lcd_d;

   lcd_cmd_scheduler #(
      .POWERUP_CYC(P),
      .LONG_CYC   (LG),
      .SHORT_CYC  (SH),
      .CNT_W      (18)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_data   (cmd_data),
      .cmd_ready  (cmd_ready),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .lcd_req    (lcd_req),
      .lcd_d      (lcd_d),
      .lcd_rs     (lcd_rs),
      .lcd_busy   (lcd_busy),
      .init_done  (init_done),
      .sched_busy (sched_busy)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   logic   rst_q = 1'b1;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Engine model: busy rises eng_lat cycles after a request and stays high eng_hold cycles.
   int     eng_lat = 1;
   int     eng_hold = 4;
   longint eng_rise = NEVER;
   longint eng_fall = NEVER;

   task automatic eng_step(input logic gl);
      if (rst_q) begin
         eng_rise = NEVER;
         eng_fall = NEVER;
      end else if (lcd_req === 1'b1) begin
         eng_rise = cyc + eng_lat;
         eng_fall = eng_rise + eng_hold;
      end
      lcd_busy = gl || (cyc >= eng_rise && cyc < eng_fall);
   endtask

   // Timeline model: each issued byte frees the scheduler at
   // issue + latency + hold + 1 + settling delay.
   typedef struct {
      longint     t;
      logic [7:0] d;
      logic       rs;
   } req_t;

   req_t       req_log[$];
   logic [7:0] rom [0:5] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
   longint     rel = 0;
   longint     m_issue_at = NEVER;
   longint     m_idle_from = NEVER;
   longint     m_done_at = NEVER;
   longint     m_c, m_end;
   int         m_idx = 0;
   int         m_n;
   logic [7:0] m_byte = '0;
   logic [7:0] m_last_d = '0;
   logic       m_rs = 1'b0, m_last_rs = 1'b0;
   logic       m_rst_prev = 1'b0, m_armed = 1'b0;
   logic       m_exp_req, m_idle;

   always @(negedge clk) begin
      #1;
      if (m_armed) begin
         m_c = cyc;
         if (m_rst_prev) begin
            rel = m_c;
            m_issue_at = m_c + P;
            m_idle_from = NEVER;
            m_done_at = NEVER;
            m_idx = 0;
            m_byte = rom[0];
            m_rs = 1'b0;
            m_last_d = '0;
            m_last_rs = 1'b0;
            req_log.delete();
         end
         m_exp_req = (m_c == m_issue_at);
         if (m_exp_req) begin
            m_last_d = m_byte;
            m_last_rs = m_rs;
         end
         m_idle = (m_c >= m_idle_from);
         if (lcd_req === 1'b1) req_log.push_back('{m_c, lcd_d, lcd_rs});
         check("lcd_req", 64'(lcd_req), 64'(m_exp_req));
         check("lcd_d", 64'(lcd_d), 64'(m_last_d));
         check("lcd_rs", 64'(lcd_rs), 64'(m_last_rs));
         check("cmd_ready", 64'(cmd_ready), 64'(m_idle));
         check("char_ready", 64'(char_ready), 64'(m_idle && !cmd_valid));
         check("sched_busy", 64'(sched_busy), 64'(!m_idle));
         check("init_done", 64'(init_done), 64'(m_c >= m_done_at));
         if (m_exp_req) begin
            m_n = (!m_rs && (m_byte == 8'h01 || m_byte == 8'h02 || m_byte == 8'h03)) ? LG : SH;
            m_end = m_c + eng_lat + eng_hold + 1 + m_n;
            m_issue_at = NEVER;
            if (m_done_at == NEVER && m_idx < 5) begin
               m_idx++;
               m_byte = rom[m_idx];
               m_rs = 1'b0;
               m_issue_at = m_end;
            end else begin
               m_idle_from = m_end;
               if (m_done_at == NEVER) m_done_at = m_end;
            end
         end
         if (m_idle && !reset && (cmd_valid || char_valid)) begin
            m_byte = cmd_valid ? cmd_data : char_data;
            m_rs = !cmd_valid;
            m_issue_at = m_c + 1;
            m_idle_from = NEVER;
         end
      end
      if (reset) m_armed = 1'b1;
      m_rst_prev = reset;
   end

   // Requesters hold valid and data until the handshake completes.
   logic       pc_v = 1'b0, ph_v = 1'b0;
   logic [7:0] pc_d = '0, ph_d = '0;
   logic       cmd_fire = 1'b0, char_fire = 1'b0;

   task automatic drive_cycle(input logic rst, input logic gl);
      @(negedge clk);
      eng_step(gl);
      reset = rst;
      cmd_valid = pc_v;
      cmd_data = pc_d;
      char_valid = ph_v;
      char_data = ph_d;
      #2;
      cmd_fire = cmd_valid && cmd_ready && !reset;
      char_fire = char_valid && char_ready && !reset;
      if (cmd_fire) pc_v = 1'b0;
      if (char_fire) ph_v = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc, output longint at);
      at = -1;
      for (int i = 0; i < max_cyc; i++) begin
         drive_cycle(1'b0, 1'b0);
         if (cmd_ready) begin
            at = cyc;
            break;
         end
      end
      check("wait_idle_in_time", 64'(at >= 0), 64'd1);
   endtask

   longint     exp_t [0:5] = '{10, 19, 28, 37, 46, 60};
   logic [7:0] exp_b [0:5] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
   longint     t_idle, f;
   int         n0;
   req_t       r1, r2;

   initial begin
      // Power-up, init sequence, command held through init.
      repeat (3) drive_cycle(1'b1, 1'b0);
      for (int i = 0; i < 200 && req_log.size() < 7; i++) begin
         if (i == 2) begin
            pc_v = 1'b1;
            pc_d = 8'hC0;
         end
         drive_cycle(1'b0, (i >= 1 && i <= 6) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      check("init_req_count", 64'(req_log.size() >= 7), 64'd1);
      if (req_log.size() >= 7) begin
         for (int i = 0; i < 6; i++) begin
            check($sformatf("init_t%0d", i), 64'(req_log[i].t - rel), 64'(exp_t[i]));
            check($sformatf("init_b%0d", i), 64'(req_log[i].d), 64'(exp_b[i]));
         end
         check("held_cmd_t", 64'(req_log[6].t - rel), 64'd70);
         check("held_cmd_d", 64'(req_log[6].d), 64'hC0);
         check("held_cmd_rs", 64'(req_log[6].rs), 64'd0);
      end
      check("model_done_at", 64'(m_done_at - rel), 64'd69);
      wait_idle(100, t_idle);
      check("idle_after_held_cmd", 64'(t_idle - rel), 64'd79);

      // Single character write.
      ph_v = 1'b1;
      ph_d = 8'h41;
      drive_cycle(1'b0, 1'b0);
      f = cyc;
      check("char41_fire", 64'(char_fire), 64'd1);
      wait_idle(100, t_idle);
      r1 = req_log[req_log.size() - 1];
      check("char41_t", 64'(r1.t - f), 64'd1);
      check("char41_d", 64'(r1.d), 64'h41);
      check("char41_rs", 64'(r1.rs), 64'd1);
      check("char41_occupancy", 64'(t_idle - f), 64'd10);

      // Simultaneous clear command and character: command wins.
      pc_v = 1'b1;
      pc_d = 8'h01;
      ph_v = 1'b1;
      ph_d = 8'h42;
      drive_cycle(1'b0, 1'b0);
      f = cyc;
      check("arb_cmd_fire", 64'(cmd_fire), 64'd1);
      check("arb_char_wait", 64'(char_fire), 64'd0);
      for (int i = 0; i < 100 && ph_v; i++) drive_cycle(1'b0, 1'b0);
      wait_idle(100, t_idle);
      r1 = req_log[req_log.size() - 2];
      r2 = req_log[req_log.size() - 1];
      check("arb_first_d", 64'(r1.d), 64'h01);
      check("arb_first_rs", 64'(r1.rs), 64'd0);
      check("arb_first_t", 64'(r1.t - f), 64'd1);
      check("arb_second_d", 64'(r2.d), 64'h42);
      check("arb_second_rs", 64'(r2.rs), 64'd1);
      check("arb_long_gap", 64'(r2.t - r1.t), 64'd15);

      // Engine holds busy for 50 cycles.
      eng_hold = 50;
      n0 = req_log.size();
      ph_v = 1'b1;
      ph_d = 8'h5A;
      drive_cycle(1'b0, 1'b0);
      f = cyc;
      wait_idle(200, t_idle);
      check("long_busy_occupancy", 64'(t_idle - f), 64'd56);
      check("long_busy_one_req", 64'(req_log.size()), 64'(n0 + 1));
      eng_hold = 4;

      // Reset during WAIT_DONE of a character write.
      ph_v = 1'b1;
      ph_d = 8'h43;
      drive_cycle(1'b0, 1'b0);
      repeat (3) drive_cycle(1'b0, 1'b0);
      drive_cycle(1'b1, 1'b0);
      drive_cycle(1'b1, 1'b0);
      check("rst_lcd_d", 64'(lcd_d), 64'h00);
      check("rst_init_done", 64'(init_done), 64'd0);
      check("rst_sched_busy", 64'(sched_busy), 64'd1);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      for (int i = 0; i < 100 && req_log.size() < 1; i++) drive_cycle(1'b0, 1'b0);
      check("restart_seen", 64'(req_log.size() >= 1), 64'd1);
      if (req_log.size() >= 1) begin
         check("restart_d", 64'(req_log[0].d), 64'h38);
         check("restart_t", 64'(req_log[0].t - rel), 64'd10);
      end
      wait_idle(300, t_idle);

      // Randomized traffic with random engine timing.
      for (int i = 0; i < 20000 && req_log.size() < 126; i++) begin
         if (!pc_v && $urandom_range(0, 5) == 0) begin
            pc_v = 1'b1;
            pc_d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
         end
         if (!ph_v && $urandom_range(0, 2) == 0) begin
            ph_v = 1'b1;
            ph_d = 8'($urandom);
         end
         eng_lat = $urandom_range(1, 3);
         eng_hold = $urandom_range(1, 6);
         drive_cycle(1'b0, 1'b0);
      end
      check("random_volume", 64'(req_log.size() >= 126), 64'd1);
      pc_v = 1'b0;
      ph_v = 1'b0;
      repeat (40) drive_cycle(1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
